// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer for a 32-word synchronous instruction memory: owns the PC, tracks the
// one-cycle read latency, buffers tagged words in a 2-entry FIFO and handles branch redirects.
module inst_fetch_ctrl #(
    parameter int AW       = 32,
    parameter int DEPTH    = 32,
    parameter int RESET_PC = 0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] mem_addr,
    input  logic [31:0]   mem_rdata,
    output logic [31:0]   inst,
    output logic [AW-1:0] inst_pc,
    output logic          inst_valid,
    input  logic          inst_ready,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [31:0]   data;
        logic [AW-1:0] pc;
    } entry_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] tag_q, tag_d;
    logic          inflight_q, inflight_d;
    logic          err_q, err_d;
    logic [1:0]    count_q, count_d;
    entry_t        fifo_q [2];
    entry_t        fifo_d [2];

    logic          target_ok;
    logic          pop;
    logic          push;
    logic          issue;
    logic [2:0]    occupancy;
    logic [1:0]    fill;
    entry_t        new_entry;

    always_comb begin
        target_ok = redirect_pc < AW'(DEPTH);
        pop       = (count_q != 2'd0) && inst_ready;
        // A redirect discards both the word returning this cycle and any pop.
        push      = inflight_q && !redirect_valid;
        occupancy = {1'b0, count_q} + {2'b00, inflight_q};
        issue     = (state_q == S_FETCH) && !redirect_valid
                    && (pc_q < AW'(DEPTH))
                    && (occupancy < (3'd2 + {2'b00, pop}));
        fill      = count_q - {1'b0, pop};
        new_entry = '{data: mem_rdata, pc: tag_q};
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tag_d      = tag_q;
        inflight_d = issue;
        err_d      = err_q;

        if (issue) begin
            pc_d  = pc_q + AW'(1);
            tag_d = pc_q;
        end

        if (redirect_valid) begin
            if (target_ok) begin
                state_d = S_FETCH;
                pc_d    = redirect_pc;
            end else begin
                err_d   = 1'b1;
                state_d = S_DONE;
            end
        end else begin
            case (state_q)
                S_IDLE:  if (start) state_d = S_FETCH;
                S_FETCH: if (pc_q == AW'(DEPTH) && !inflight_q && count_q == 2'd0)
                             state_d = S_DONE;
                S_DONE:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Head always lives in slot 0; a pop shifts slot 1 down before the new word lands.
    always_comb begin
        fifo_d  = fifo_q;
        count_d = count_q;
        if (redirect_valid) begin
            count_d = 2'd0;
        end else begin
            if (pop) fifo_d[0] = fifo_q[1];
            if (push) fifo_d[fill[0]] = new_entry;
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= AW'(RESET_PC);
            tag_q      <= '0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= 2'd0;
            // NOTE: the two FIFO slots are cleared too; they are tiny and it keeps state deterministic.
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
            count_q    <= count_d;
            fifo_q[0]  <= fifo_d[0];
            fifo_q[1]  <= fifo_d[1];
        end
    end

    assign mem_addr   = pc_q;
    assign inst_valid = (count_q != 2'd0);
    assign inst       = inst_valid ? fifo_q[0].data : 32'd0;
    assign inst_pc    = inst_valid ? fifo_q[0].pc : '0;
    assign done       = (state_q == S_DONE);
    assign err        = err_q;

    count_le_two: assert property (@(posedge clock) disable iff (reset) count_q <= 2'd2);

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: a per-cycle vector table for streaming, redirect,
// end-of-memory and error handling, plus hand-written stall and mid-stream reset sequences.
module tb_inst_fetch_ctrl;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [32];

    inst_fetch_ctrl #(.AW(32), .DEPTH(32), .RESET_PC(0)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .done          (done),
        .err           (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Registered-read instruction memory.
    always @(posedge clock) mem_rdata <= mem[mem_addr[4:0]];

    typedef struct {
        logic        start;
        logic        ready;
        logic        rv;
        logic [31:0] rpc;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_done;
        logic        e_err;
    } vec_t;

    vec_t vecs [25];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic r, input logic rv, input logic [31:0] rpc);
        @(negedge clock);
        start          = s;
        inst_ready     = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset          = 1'b1;
        start          = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
    endtask

    function automatic vec_t mk(input logic s, input logic rv, input logic [31:0] rpc,
                                input logic ev, input logic [31:0] epc,
                                input logic ed, input logic ee);
        vec_t v;
        v.start   = s;
        v.ready   = 1'b1;
        v.rv      = rv;
        v.rpc     = rpc;
        v.e_valid = ev;
        v.e_pc    = ev ? epc : 32'd0;
        v.e_inst  = ev ? 32'h1000 + epc : 32'd0;
        v.e_done  = ed;
        v.e_err   = ee;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 32; k++) mem[k] = 32'h1000 + k;
        reset = 1'b1;
        start = 1'b0;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;

        // Streaming from 0, redirect to 20, redirect to 29 and run off the end,
        // out-of-range redirect to 40, then recovery at 3 with err still set.
        vecs[0]  = mk(1, 0, 0,  0, 0,  0, 0);
        vecs[1]  = mk(0, 0, 0,  0, 0,  0, 0);
        vecs[2]  = mk(0, 0, 0,  1, 0,  0, 0);
        vecs[3]  = mk(0, 0, 0,  1, 1,  0, 0);
        vecs[4]  = mk(0, 0, 0,  1, 2,  0, 0);
        vecs[5]  = mk(0, 0, 0,  1, 3,  0, 0);
        vecs[6]  = mk(0, 1, 20, 0, 0,  0, 0);
        vecs[7]  = mk(0, 0, 0,  0, 0,  0, 0);
        vecs[8]  = mk(0, 0, 0,  1, 20, 0, 0);
        vecs[9]  = mk(0, 0, 0,  1, 21, 0, 0);
        vecs[10] = mk(0, 1, 29, 0, 0,  0, 0);
        vecs[11] = mk(0, 0, 0,  0, 0,  0, 0);
        vecs[12] = mk(0, 0, 0,  1, 29, 0, 0);
        vecs[13] = mk(0, 0, 0,  1, 30, 0, 0);
        vecs[14] = mk(0, 0, 0,  1, 31, 0, 0);
        vecs[15] = mk(0, 0, 0,  0, 0,  0, 0);
        vecs[16] = mk(0, 0, 0,  0, 0,  1, 0);
        vecs[17] = mk(0, 0, 0,  0, 0,  1, 0);
        vecs[18] = mk(0, 1, 3,  0, 0,  0, 0);
        vecs[19] = mk(0, 1, 40, 0, 0,  1, 1);
        vecs[20] = mk(0, 0, 0,  0, 0,  1, 1);
        vecs[21] = mk(0, 1, 3,  0, 0,  0, 1);
        vecs[22] = mk(0, 0, 0,  0, 0,  0, 1);
        vecs[23] = mk(0, 0, 0,  1, 3,  0, 1);
        vecs[24] = mk(0, 0, 0,  1, 4,  0, 1);

        do_reset();
        check("reset inst_valid", {31'd0, inst_valid}, 32'd0);
        check("reset inst",       inst,                32'd0);
        check("reset inst_pc",    inst_pc,             32'd0);
        check("reset mem_addr",   mem_addr,            32'd0);
        check("reset done",       {31'd0, done},       32'd0);
        check("reset err",        {31'd0, err},        32'd0);

        for (int i = 0; i < 25; i++) begin
            step(vecs[i].start, vecs[i].ready, vecs[i].rv, vecs[i].rpc);
            check($sformatf("vec%0d valid", i), {31'd0, inst_valid}, {31'd0, vecs[i].e_valid});
            check($sformatf("vec%0d pc", i),    inst_pc,             vecs[i].e_pc);
            check($sformatf("vec%0d inst", i),  inst,                vecs[i].e_inst);
            check($sformatf("vec%0d done", i),  {31'd0, done},       {31'd0, vecs[i].e_done});
            check($sformatf("vec%0d err", i),   {31'd0, err},        {31'd0, vecs[i].e_err});
        end

        // Mid-stream asynchronous reset with the FIFO full.
        step(0, 0, 0, 0);
        check("pre-reset valid", {31'd0, inst_valid}, 32'd1);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("async reset valid", {31'd0, inst_valid}, 32'd0);
        check("async reset inst",  inst,                32'd0);
        check("async reset pc",    inst_pc,             32'd0);
        check("async reset addr",  mem_addr,            32'd0);
        check("async reset err",   {31'd0, err},        32'd0);
        check("async reset done",  {31'd0, done},       32'd0);
        @(negedge clock);
        reset = 1'b0;
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        check("restart not yet valid", {31'd0, inst_valid}, 32'd0);
        step(0, 1, 0, 0);
        check("restart valid", {31'd0, inst_valid}, 32'd1);
        check("restart pc",    inst_pc,             32'd0);
        check("restart inst",  inst,                32'h1000);

        // Decode stall: FIFO fills to two, issue stops, then drains in order.
        do_reset();
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int c = 0; c < 6; c++) begin
            step(0, 0, 0, 0);
            check($sformatf("stall%0d valid", c), {31'd0, inst_valid}, 32'd1);
            check($sformatf("stall%0d pc", c),    inst_pc,             32'd0);
            check($sformatf("stall%0d addr", c),  mem_addr,            32'd2);
        end
        for (int k = 1; k <= 6; k++) begin
            step(0, 1, 0, 0);
            check($sformatf("drain%0d valid", k), {31'd0, inst_valid}, 32'd1);
            check($sformatf("drain%0d pc", k),    inst_pc,             32'(k));
            check($sformatf("drain%0d inst", k),  inst,                32'h1000 + 32'(k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
